// File: rtl/bus_control_unit.sv
// bus_control_unit: multi-cycle sequencer for the 8-bit common-bus CPU.
// Fetches an instruction over a req/ack handshake, decodes the IR fields
// and steps the datapath through bus select, load enables, RF write and ALU op.

module bus_control_unit #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [13:0]      ir,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic [1:0]       data_bus_sel,
  output logic             pc_load_en,
  output logic             pc_inc,
  output logic             ir_load_en,
  output logic             alu_src1_load_en,
  output logic             alu_src2_load_en,
  output logic             sel_field_load_en,
  output logic [1:0]       reg_address,
  output logic             rf_write_read,
  output logic [2:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SRC1, SRC2, EXEC, WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_JMP = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  // Bus source encodings
  localparam logic [1:0] BUS_PC  = 2'b00;
  localparam logic [1:0] BUS_IR  = 2'b01;
  localparam logic [1:0] BUS_ALU = 2'b10;
  localparam logic [1:0] BUS_RF  = 2'b11;

  // The wait counter only has to reach FETCH_TIMEOUT-1
  localparam int TW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;

  state_t           state;
  state_t           next_state;
  logic [TW-1:0]    wait_cnt;
  logic             timeout_hit;
  logic             set_fault;
  logic             fault_q;
  logic [2:0]       op_bits;
  opcode_t          op;
  logic [1:0]       rd;
  logic [1:0]       rs;
  state_t           boundary;
  logic             unused_imm;

  assign op_bits = ir[13:11];
  assign op      = opcode_t'(op_bits);
  assign rd      = ir[10:9];
  assign rs      = ir[8:7];

  // The immediate goes to the datapath over the bus, not through this block
  assign unused_imm = ^ir[6:0];

  // A timeout of zero disables the fetch watchdog entirely
  assign timeout_hit = (FETCH_TIMEOUT != 0) && (int'(wait_cnt) == FETCH_TIMEOUT - 1);

  // Instruction boundary: run picks between fetching again and idling
  assign boundary = run ? FETCH : IDLE;

  assign fault = fault_q;

  // State, fetch-wait counter, retire counter and sticky fault flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      retired_cnt <= '0;
      fault_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH && next_state == FETCH) begin
        wait_cnt <= wait_cnt + TW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (retire) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (set_fault) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Next-state and datapath controls; Moore except the fetch-ack strobes
  always_comb begin
    next_state        = state;
    set_fault         = 1'b0;
    fetch_req         = 1'b0;
    data_bus_sel      = BUS_PC;
    pc_load_en        = 1'b0;
    pc_inc            = 1'b0;
    ir_load_en        = 1'b0;
    alu_src1_load_en  = 1'b0;
    alu_src2_load_en  = 1'b0;
    sel_field_load_en = 1'b0;
    reg_address       = 2'b00;
    rf_write_read     = 1'b0;
    alu_op            = 3'b000;
    retire            = 1'b0;
    halted            = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          next_state = FETCH;
        end
      end

      FETCH: begin
        fetch_req    = 1'b1;
        data_bus_sel = BUS_PC;
        if (fetch_ack) begin
          ir_load_en = 1'b1;
          pc_inc     = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          set_fault  = 1'b1;
          next_state = HALT;
        end
      end

      DECODE: begin
        case (op)
          OP_NOP: begin
            retire     = 1'b1;
            next_state = boundary;
          end
          OP_JMP: begin
            data_bus_sel = BUS_IR;
            pc_load_en   = 1'b1;
            retire       = 1'b1;
            next_state   = boundary;
          end
          OP_HLT: begin
            retire     = 1'b1;
            next_state = HALT;
          end
          OP_LDI: begin
            sel_field_load_en = 1'b1;
            reg_address       = rd;
            next_state        = WB;
          end
          default: begin
            sel_field_load_en = 1'b1;
            reg_address       = rd;
            next_state        = SRC1;
          end
        endcase
      end

      SRC1: begin
        data_bus_sel      = BUS_RF;
        alu_src1_load_en  = 1'b1;
        sel_field_load_en = 1'b1;
        reg_address       = rs;
        next_state        = SRC2;
      end

      SRC2: begin
        data_bus_sel      = BUS_RF;
        alu_src2_load_en  = 1'b1;
        sel_field_load_en = 1'b1;
        reg_address       = rd;
        next_state        = EXEC;
      end

      EXEC: begin
        data_bus_sel  = BUS_ALU;
        alu_op        = op_bits - 3'b010;
        rf_write_read = 1'b1;
        retire        = 1'b1;
        next_state    = boundary;
      end

      WB: begin
        data_bus_sel  = BUS_IR;
        rf_write_read = 1'b1;
        retire        = 1'b1;
        next_state    = boundary;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_control_unit.sv
// tb_bus_control_unit: scoreboard bench for the bus control unit.
// Each instruction pushes per-cycle stimulus and expected controls into
// queues; the drain loop drives one cycle at a time and compares.

module tb_bus_control_unit;

  localparam int FETCH_TIMEOUT = 4;
  localparam int CNT_W         = 4;

  typedef struct packed {
    logic       fetch_req;
    logic [1:0] sel;
    logic       pc_load_en;
    logic       pc_inc;
    logic       ir_load_en;
    logic       src1;
    logic       src2;
    logic       sel_field;
    logic [1:0] reg_address;
    logic       rf_wr;
    logic [2:0] alu_op;
    logic       retire;
    logic       halted;
    logic       fault;
  } ctrl_t;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        ack;
    logic        ldir;
    logic [13:0] word;
  } stim_t;

  logic             clock;
  logic             reset;
  logic             run;
  logic [13:0]      ir;
  logic             fetch_req;
  logic             fetch_ack;
  logic [1:0]       data_bus_sel;
  logic             pc_load_en;
  logic             pc_inc;
  logic             ir_load_en;
  logic             alu_src1_load_en;
  logic             alu_src2_load_en;
  logic             sel_field_load_en;
  logic [1:0]       reg_address;
  logic             rf_write_read;
  logic [2:0]       alu_op;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             halted;
  logic             fault;

  stim_t            stim_q[$];
  ctrl_t            exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];
  string            tag_q[$];

  logic [CNT_W-1:0] exp_cnt;
  ctrl_t            zero_ctl;
  int               checks;
  int               errors;

  bus_control_unit #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .ir(ir),
    .fetch_req(fetch_req),
    .fetch_ack(fetch_ack),
    .data_bus_sel(data_bus_sel),
    .pc_load_en(pc_load_en),
    .pc_inc(pc_inc),
    .ir_load_en(ir_load_en),
    .alu_src1_load_en(alu_src1_load_en),
    .alu_src2_load_en(alu_src2_load_en),
    .sel_field_load_en(sel_field_load_en),
    .reg_address(reg_address),
    .rf_write_read(rf_write_read),
    .alu_op(alu_op),
    .retire(retire),
    .retired_cnt(retired_cnt),
    .halted(halted),
    .fault(fault)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Queue one cycle of stimulus with its expected controls and count
  task automatic push_cycle(input logic rst, input logic rn, input logic ack, input logic ldir,
                            input logic [13:0] word, input ctrl_t exp, input string tag);
    stim_t s;
    s.rst  = rst;
    s.run  = rn;
    s.ack  = ack;
    s.ldir = ldir;
    s.word = word;
    stim_q.push_back(s);
    exp_q.push_back(exp);
    cnt_q.push_back(exp_cnt);
    tag_q.push_back(tag);
    if (rst) exp_cnt = '0;
    else if (exp.retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Queue a whole instruction: fetch wait cycles, the ack cycle, then execution
  task automatic push_instr(input logic [13:0] word, input int delay, input logic noisy,
                            input logic drop_run, input logic rst_exec);
    ctrl_t      e;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    op = word[13:11];
    rd = word[10:9];
    rs = word[8:7];
    for (int i = 0; i < delay; i++) begin
      e = zero_ctl;
      e.fetch_req = 1'b1;
      push_cycle(1'b0, 1'b1, 1'b0, 1'b0, word, e, "fetch_wait");
    end
    e = zero_ctl;
    e.fetch_req  = 1'b1;
    e.ir_load_en = 1'b1;
    e.pc_inc     = 1'b1;
    push_cycle(1'b0, 1'b1, 1'b1, 1'b1, word, e, "fetch_ack");
    e = zero_ctl;
    case (op)
      3'b000: begin
        e.retire = 1'b1;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "nop_decode");
      end
      3'b110: begin
        e.sel        = 2'b01;
        e.pc_load_en = 1'b1;
        e.retire     = 1'b1;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "jmp_decode");
      end
      3'b111: begin
        e.retire = 1'b1;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "hlt_decode");
      end
      3'b001: begin
        e.sel_field   = 1'b1;
        e.reg_address = rd;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "ldi_decode");
        e = zero_ctl;
        e.sel    = 2'b01;
        e.rf_wr  = 1'b1;
        e.retire = 1'b1;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "ldi_wb");
      end
      default: begin
        e.sel_field   = 1'b1;
        e.reg_address = rd;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "alu_decode");
        e = zero_ctl;
        e.sel         = 2'b11;
        e.src1        = 1'b1;
        e.sel_field   = 1'b1;
        e.reg_address = rs;
        push_cycle(1'b0, 1'b1, noisy, 1'b0, word, e, "alu_src1");
        e = zero_ctl;
        e.sel         = 2'b11;
        e.src2        = 1'b1;
        e.sel_field   = 1'b1;
        e.reg_address = rd;
        push_cycle(1'b0, !drop_run, noisy, 1'b0, word, e, "alu_src2");
        e = zero_ctl;
        e.sel    = 2'b10;
        e.alu_op = op - 3'd2;
        e.rf_wr  = 1'b1;
        e.retire = 1'b1;
        push_cycle(rst_exec, !drop_run, noisy, 1'b0, word, e, "alu_exec");
      end
    endcase
  endtask

  // Drive one queued cycle, compare outputs, then let the clock edge land
  task automatic applyStimulus();
    stim_t            s;
    ctrl_t            exp;
    ctrl_t            obs;
    logic [CNT_W-1:0] ecnt;
    string            tag;
    s    = stim_q.pop_front();
    exp  = exp_q.pop_front();
    ecnt = cnt_q.pop_front();
    tag  = tag_q.pop_front();
    reset     = s.rst;
    run       = s.run;
    fetch_ack = s.ack;
    #1;
    obs.fetch_req   = fetch_req;
    obs.sel         = data_bus_sel;
    obs.pc_load_en  = pc_load_en;
    obs.pc_inc      = pc_inc;
    obs.ir_load_en  = ir_load_en;
    obs.src1        = alu_src1_load_en;
    obs.src2        = alu_src2_load_en;
    obs.sel_field   = sel_field_load_en;
    obs.reg_address = reg_address;
    obs.rf_wr       = rf_write_read;
    obs.alu_op      = alu_op;
    obs.retire      = retire;
    obs.halted      = halted;
    obs.fault       = fault;
    checkOutput({tag, "/ctl"}, 32'(obs), 32'(exp));
    checkOutput({tag, "/cnt"}, 32'(retired_cnt), 32'(ecnt));
    @(posedge clock);
    #1;
    if (s.ldir) ir = s.word;
    @(negedge clock);
  endtask

  // Build the whole scenario, then drain it cycle by cycle
  initial begin
    ctrl_t e;
    checks    = 0;
    errors    = 0;
    exp_cnt   = '0;
    zero_ctl  = '0;
    reset     = 1'b1;
    run       = 1'b0;
    fetch_ack = 1'b0;
    ir        = '0;

    push_cycle(1'b0, 1'b0, 1'b0, 1'b0, 14'h0, zero_ctl, "reset");
    push_cycle(1'b0, 1'b1, 1'b0, 1'b0, 14'h0, zero_ctl, "idle_run");

    push_instr({3'b001, 2'b01, 9'h02A}, 0, 1'b0, 1'b0, 1'b0);
    push_instr({3'b001, 2'b00, 9'h005}, 0, 1'b0, 1'b0, 1'b0);
    push_instr({3'b001, 2'b01, 9'h003}, 0, 1'b0, 1'b0, 1'b0);
    push_instr({3'b011, 2'b00, 2'b01, 7'h00}, 0, 1'b0, 1'b0, 1'b0);
    push_instr({3'b110, 2'b00, 9'h0F0}, 0, 1'b0, 1'b0, 1'b0);
    push_instr({3'b010, 2'b10, 2'b10, 7'h00}, 3, 1'b1, 1'b0, 1'b0);
    push_instr({3'b100, 2'b11, 2'b00, 7'h11}, 1, 1'b0, 1'b0, 1'b0);
    push_instr({3'b101, 2'b01, 2'b10, 7'h05}, 2, 1'b1, 1'b0, 1'b0);

    push_instr({3'b010, 2'b00, 2'b01, 7'h00}, 0, 1'b0, 1'b1, 1'b0);
    push_cycle(1'b0, 1'b0, 1'b1, 1'b0, 14'h0, zero_ctl, "idle_after_drop");
    push_cycle(1'b0, 1'b1, 1'b0, 1'b0, 14'h0, zero_ctl, "idle_rerun");

    for (int i = 0; i < 8; i++) begin
      push_instr({3'b000, 11'(i)}, i % 4, 1'(i % 2), 1'b0, 1'b0);
    end

    push_instr({3'b101, 2'b10, 2'b11, 7'h00}, 0, 1'b0, 1'b0, 1'b1);
    push_cycle(1'b0, 1'b1, 1'b0, 1'b0, 14'h0, zero_ctl, "after_exec_rst");

    push_instr({3'b111, 11'h0}, 0, 1'b0, 1'b0, 1'b0);
    e = zero_ctl;
    e.halted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_cycle(1'b0, 1'b1, 1'b1, 1'b0, 14'h0, e, "halt_hold");
    end
    push_cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0, e, "halt_rst");
    push_cycle(1'b0, 1'b1, 1'b0, 1'b0, 14'h0, zero_ctl, "after_halt_rst");

    e = zero_ctl;
    e.fetch_req = 1'b1;
    for (int i = 0; i < FETCH_TIMEOUT; i++) begin
      push_cycle(1'b0, 1'b1, 1'b0, 1'b0, 14'h0, e, "timeout_wait");
    end
    e = zero_ctl;
    e.halted = 1'b1;
    e.fault  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_cycle(1'b0, 1'b1, 1'b1, 1'b0, 14'h0, e, "timeout_hold");
    end
    push_cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, e, "fault_rst");
    push_cycle(1'b0, 1'b0, 1'b0, 1'b0, 14'h0, zero_ctl, "final");

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    $display("[TB] running %0d queued cycles", stim_q.size());
    while (stim_q.size() > 0) begin
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
